// File: rtl/uart_tx.sv
// 8N1 UART transmitter: takes one byte over a four-phase req/ack handshake
// and shifts it out LSB-first on a registered, idle-high tx line.
module uart_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_out,
    input  logic       req,
    output logic       ack,
    output logic       busy,
    output logic       tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_END = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shreg, shreg_n;
    logic              tx_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        case (state)
            IDLE: if (req) begin
                state_n   = START;
                shreg_n   = d_out;
                baud_n    = '0;
                bit_cnt_n = '0;
            end
            START: if (baud == BIT_END) begin
                baud_n  = '0;
                state_n = DATA;
            end else begin
                baud_n = baud + 1'b1;
            end
            DATA: if (baud == BIT_END) begin
                baud_n    = '0;
                shreg_n   = {1'b0, shreg[7:1]};
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = STOP;
            end else begin
                baud_n = baud + 1'b1;
            end
            STOP: if (baud == STOP_END) begin
                baud_n  = '0;
                state_n = DONE;
            end else begin
                baud_n = baud + 1'b1;
            end
            DONE: if (!req) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // tx is registered from the next-state view so it changes exactly at bit boundaries
        tx_n = 1'b1;
        if (state_n == START)     tx_n = 1'b0;
        else if (state_n == DATA) tx_n = shreg_n[0];
    end

    assign ack  = (state == DONE);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two instances (1 and 2 stop bits, 16 clocks/bit)
// checked cycle by cycle against hand-computed frames, plus a serial decoder loopback.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d1, d2;
    logic       req1, req2;
    logic       ack1, busy1, tx1;
    logic       ack2, busy2, tx2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .d_out(d1), .req(req1),
        .ack(ack1), .busy(busy1), .tx(tx1)
    );

    uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .d_out(d2), .req(req2),
        .ack(ack2), .busy(busy2), .tx(tx2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {tx, ack, busy} of the selected instance
    function automatic logic [2:0] st(input int w);
        return (w == 1) ? {tx1, ack1, busy1} : {tx2, ack2, busy2};
    endfunction

    task automatic drive(input int w, input logic [7:0] b, input logic r);
        if (w == 1) begin d1 = b; req1 = r; end
        else        begin d2 = b; req2 = r; end
    endtask

    // bits9: {data, start} as expected on the wire, LSB first
    task automatic run_frame(input string tag, input int w, input logic [7:0] b,
                             input logic [8:0] bits9, input int stop_cyc,
                             input logic poke, input int hold_cyc);
        logic exp_bit;
        drive(w, b, 1'b1);
        tick();  // acceptance edge N; now in cycle N+1
        for (int i = 0; i < 144 + stop_cyc; i++) begin
            exp_bit = (i < 144) ? bits9[i / 16] : 1'b1;
            chk({tag, "_bit"}, st(w), {exp_bit, 1'b0, 1'b1});
            if (poke && i == 70) drive(w, 8'h00, 1'b1);
            tick();
        end
        chk({tag, "_ack_rise"}, st(w), 3'b111);
        for (int i = 0; i < hold_cyc; i++) begin
            tick();
            chk({tag, "_hold"}, st(w), 3'b111);
        end
        drive(w, 8'h00, 1'b0);
        tick();
        chk({tag, "_release"}, st(w), 3'b100);
        tick();
        chk({tag, "_idle"}, st(w), 3'b100);
    endtask

    // Independent mid-bit sampling receiver on tx1
    task automatic loopback(input logic [7:0] b);
        logic [7:0] rx;
        int         n;
        rx = '0;
        drive(1, b, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (tx1 && n < 100);
        if (tx1) begin
            chk("lb_start_timeout", 32'd1, 32'd0);
        end else begin
            repeat (7) tick();
            chk("lb_start_mid", {31'd0, tx1}, 32'd0);
            for (int k = 0; k < 8; k++) begin
                repeat (16) tick();
                rx[k] = tx1;
            end
            repeat (16) tick();
            chk("lb_stop", {31'd0, tx1}, 32'd1);
            n = 0;
            while (!ack1 && n < 50) begin
                tick();
                n++;
            end
            chk("lb_ack", {31'd0, ack1}, 32'd1);
            chk("lb_data", {24'd0, rx}, {24'd0, b});
        end
        drive(1, 8'h00, 1'b0);
        n = 0;
        while (ack1 && n < 10) begin
            tick();
            n++;
        end
        chk("lb_ack_drop", {31'd0, ack1}, 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        d1 = '0; d2 = '0; req1 = 1'b0; req2 = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_u1", st(1), 3'b100);
            chk("rst_u2", st(2), 3'b100);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_u1", st(1), 3'b100);
        chk("post_rst_u2", st(2), 3'b100);

        // 0x55 -> start 0, then 1,0,1,0,1,0,1,0
        run_frame("f55", 1, 8'h55, 9'h0AA, 16, 1'b0, 500);
        // 0xA3 -> start 0, then 1,1,0,0,0,1,0,1; d_out cleared mid-frame
        run_frame("fA3", 2, 8'hA3, 9'h146, 32, 1'b1, 3);

        // reset during data bit 3 of 0xFF (bit 3 spans frame cycles 65..80)
        drive(1, 8'hFF, 1'b1);
        tick();
        repeat (69) tick();
        chk("mid_busy", st(1), 3'b101);
        rst = 1'b1;
        req1 = 1'b0;
        tick();
        chk("mid_rst", st(1), 3'b100);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("mid_quiet", st(1), 3'b100);
        end

        for (int i = 0; i < 5; i++) loopback(8'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the sending end of the 8N1 link whose receiving end is `uart_rx`. It accepts one byte from a local host over a four-phase req/ack handshake. It serialises the byte LSB-first onto `tx` at a fixed baud rate derived from the 100 MHz system clock (default 9600 baud). It sits between the host logic and the board's UART TX pin.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per bit (100 MHz / 9600). Must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `d_out`, input, 8: byte to send. Sampled only on the acceptance cycle.
- `req`, input, 1: host request. Level-sensitive.
- `ack`, output, 1: frame complete; held high until `req` is low.
- `busy`, output, 1: high whenever the state is not IDLE.
- `tx`, output, 1: serial line, idle high. Registered output, no glitches.

## Operation
- Frame format: start bit (0), then `d_out[0]` through `d_out[7]`, then `STOP_BITS` stop bits (1).
- Each bit is held for exactly `CLKS_PER_BIT` cycles.
- State machine: IDLE → START → DATA → STOP → DONE → IDLE.
  - IDLE: `tx`=1, `ack`=0. If `req`=1, latch `d_out` into an 8-bit shift register, clear the baud and bit counters, and go to START.
  - START: `tx`=0. When the baud counter reaches `CLKS_PER_BIT-1`, clear it and go to DATA.
  - DATA: `tx`=shreg[0]. At each bit end, shift right and increment the 3-bit bit counter. After bit 7 ends (counter wraps from 7), go to STOP.
  - STOP: `tx`=1 for `STOP_BITS*CLKS_PER_BIT` cycles, then go to DONE.
  - DONE: `ack`=1, `tx`=1. When `req`=0 is sampled, go to IDLE (`ack` drops).
- Baud counter width is `$clog2(CLKS_PER_BIT*STOP_BITS)`. It counts 0..limit-1 and never overflows.
- Changes to `d_out` or `req` during START, DATA or STOP have no effect.
- `req` still high in DONE: stay in DONE with `ack`=1. Never start a second frame without `req` first going low.
- `req` high in the same cycle that DONE is left: impossible by construction, because DONE exits only on `req`=0.
- `req` high when reset is released: the frame starts on the first non-reset cycle (level-sensitive).
- Reset at any time, including mid-frame: on the next edge `tx`=1, `ack`=0, `busy`=0, state IDLE. The partial frame is abandoned; no completion stop bit is sent.

## Timing
- Reset values: `tx`=1, `ack`=0, `busy`=0, state IDLE, all counters 0.
- Acceptance: `req` is sampled high in IDLE on edge N.
  - `tx` falls and `busy` rises after edge N.
  - The start bit occupies cycles N+1 .. N+`CLKS_PER_BIT`.
- Data bit k occupies cycles N+1+(k+1)·`CLKS_PER_BIT` for `CLKS_PER_BIT` cycles.
- The stop region ends at N+(9+`STOP_BITS`)·`CLKS_PER_BIT`.
- `ack` rises on the next cycle, N+(9+`STOP_BITS`)·`CLKS_PER_BIT`+1.
- Release: `req` is sampled low in DONE on edge M. `ack` and `busy` are both 0 after edge M.
  - A new `req` can be accepted on edge M+1 at the earliest.
- Back-to-back frames: minimum gap between frames is 2 cycles of idle-high beyond the stop bits.

## Test plan
- Reset with `req`=0: assert `rst` for 10 cycles. Require `tx`=1, `ack`=0, `busy`=0 for every cycle of reset and after it.
- `CLKS_PER_BIT`=16, send 0x55:
  - `tx` must be 0,1,0,1,0,1,0,1,0,1 across cycles, each value held 16 cycles, starting the cycle after acceptance.
  - `ack` must rise at acceptance+161.
- `CLKS_PER_BIT`=16, `STOP_BITS`=2, send 0xA3:
  - Bits must be 0,1,1,0,0,0,1,0,1, then `tx`=1 for 32 cycles.
  - `ack` must rise at acceptance+177.
  - Change `d_out` to 0x00 mid-frame; the waveform must be unchanged.
- Hold `req` high for 500 cycles after `ack` rises: `tx` stays 1, `busy` stays 1, `ack` stays 1. Drop `req`: `ack` and `busy` are 0 on the next cycle.
- Reset mid-frame: assert `rst` during data bit 3 of 0xFF. Require `tx`=1 and `ack`=0 on the next cycle, and no further transitions until a new `req`.
- Loopback at default parameters: connect to `uart_rx` (`rx`=`tx`) and send 5 `$random` bytes using the handshake. Each `d_in` must equal the byte sent, with no framing loss, within 600 000 cycles total.
